// File: rtl/dino_game_ctrl.sv
// Game sequencer for the dino runner: debounced jump button, round state machine,
// score/speed ramp and high-score tracking. Every output is registered.
module dino_game_ctrl #(
  parameter logic [23:0] SPEED_INIT       = 24'd200000,
  parameter logic [23:0] SPEED_MIN        = 24'd50000,
  parameter logic [23:0] SPEED_STEP       = 24'd5000,
  parameter int unsigned SCORE_STEP       = 100,
  parameter int unsigned DEBOUNCE_CYCLES  = 1000,
  parameter int unsigned DEAD_HOLD_FRAMES = 30
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic        btn_jump,
  input  logic        collision,
  input  logic        frame_tick,
  output logic        game_rst,
  output logic        halt,
  output logic        jump,
  output logic [23:0] speed,
  output logic [15:0] score,
  output logic [15:0] hi_score,
  output logic [1:0]  state
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RAMP_W = $clog2(SCORE_STEP + 1);
  localparam int LOCK_W = $clog2(DEAD_HOLD_FRAMES + 2);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(SCORE_STEP - 1);
  localparam logic [LOCK_W-1:0] LOCK_HOLD = LOCK_W'(DEAD_HOLD_FRAMES);

  typedef enum logic [1:0] {
    ST_ATTRACT = 2'd0,
    ST_START   = 2'd1,
    ST_RUN     = 2'd2,
    ST_DEAD    = 2'd3
  } state_e;

  logic              sync1_q, sync2_q;
  logic              db_q, db_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              press_q, press_d;
  state_e            state_q, state_d;
  logic [RAMP_W-1:0] ramp_q, ramp_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic [23:0]       speed_q, speed_d;
  logic [15:0]       score_q, score_d;
  logic [15:0]       hi_q, hi_d;
  logic              halt_q, game_rst_q, jump_q, jump_d;
  logic [24:0]       spd_sub;

  // Debouncer: level flips only after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    press_d  = 1'b0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d    = sync2_q;
        press_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    score_d = score_q;
    ramp_d  = ramp_q;
    lock_d  = lock_q;
    hi_d    = hi_q;
    jump_d  = 1'b0;
    // 25-bit subtract so a step larger than speed cannot wrap past the floor
    spd_sub = {1'b0, speed_q} - {1'b0, SPEED_STEP};
    case (state_q)
      ST_ATTRACT: if (press_q) state_d = ST_START;
      ST_START:   state_d = ST_RUN;
      ST_RUN: begin
        if (collision) begin
          state_d = ST_DEAD;
          if (score_q > hi_q) hi_d = score_q;
        end else begin
          jump_d = press_q;
          if (frame_tick) begin
            if (score_q != 16'hFFFF) score_d = score_q + 1'b1;
            if (ramp_q == RAMP_LAST) begin
              ramp_d  = '0;
              speed_d = (spd_sub[24] || (spd_sub[23:0] < SPEED_MIN)) ? SPEED_MIN : spd_sub[23:0];
            end else begin
              ramp_d = ramp_q + 1'b1;
            end
          end
        end
      end
      ST_DEAD: begin
        if (frame_tick && (lock_q < LOCK_HOLD)) lock_d = lock_q + 1'b1;
        if (press_q && (lock_q >= LOCK_HOLD)) state_d = ST_START;
      end
      default: state_d = ST_ATTRACT;
    endcase
    // Round setup happens on the edge into START so START already shows it
    if ((state_d == ST_START) && (state_q != ST_START)) begin
      speed_d = SPEED_INIT;
      score_d = '0;
      ramp_d  = '0;
    end
    if ((state_d == ST_DEAD) && (state_q != ST_DEAD)) lock_d = '0;
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_q       <= 1'b0;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
      state_q    <= ST_ATTRACT;
      ramp_q     <= '0;
      lock_q     <= '0;
      speed_q    <= SPEED_INIT;
      score_q    <= '0;
      hi_q       <= '0;
      halt_q     <= 1'b1;
      game_rst_q <= 1'b0;
      jump_q     <= 1'b0;
    end else begin
      sync1_q    <= btn_jump;
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
      state_q    <= state_d;
      ramp_q     <= ramp_d;
      lock_q     <= lock_d;
      speed_q    <= speed_d;
      score_q    <= score_d;
      hi_q       <= hi_d;
      halt_q     <= (state_d != ST_RUN);
      game_rst_q <= (state_d == ST_START);
      jump_q     <= jump_d;
    end
  end

  assign game_rst = game_rst_q;
  assign halt     = halt_q;
  assign jump     = jump_q;
  assign speed    = speed_q;
  assign score    = score_q;
  assign hi_score = hi_q;
  assign state    = state_q;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Bench for dino_game_ctrl: directed round scenarios, then random button/tick/collision
// traffic, all outputs compared every cycle against a behavioural model.
module tb_dino_game_ctrl;

  localparam int SI = 100, SMIN = 20, SST = 30, SS = 3, DEB = 4, HOLD = 2;

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        btn_jump = 1'b0, collision = 1'b0, frame_tick = 1'b0;
  logic        game_rst, halt, jump;
  logic [23:0] speed;
  logic [15:0] score, hi_score;
  logic [1:0]  state;

  int nchk = 0, nerr = 0;

  dino_game_ctrl #(
    .SPEED_INIT(24'd100), .SPEED_MIN(24'd20), .SPEED_STEP(24'd30),
    .SCORE_STEP(3), .DEBOUNCE_CYCLES(4), .DEAD_HOLD_FRAMES(2)
  ) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .btn_jump(btn_jump), .collision(collision),
    .frame_tick(frame_tick), .game_rst(game_rst), .halt(halt), .jump(jump),
    .speed(speed), .score(score), .hi_score(hi_score), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: 0=ATTRACT 1=START 2=RUN 3=DEAD, plain integer bookkeeping
  int m_st = 0, m_score = 0, m_speed = SI, m_ramp = 0, m_hi = 0, m_lock = 0, m_run = 0;
  bit m_jump = 0, m_s1 = 0, m_s2 = 0, m_lvl = 0, m_press = 0;

  task automatic m_new_round();
    m_st = 1; m_score = 0; m_speed = SI; m_ramp = 0;
  endtask

  always @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_st = 0; m_score = 0; m_speed = SI; m_ramp = 0; m_hi = 0; m_lock = 0;
      m_run = 0; m_jump = 0; m_s1 = 0; m_s2 = 0; m_lvl = 0; m_press = 0;
    end else begin
      m_jump = 0;
      case (m_st)
        0: if (m_press) m_new_round();
        1: m_st = 2;
        2: if (collision) begin
             if (m_score > m_hi) m_hi = m_score;
             m_st = 3; m_lock = 0;
           end else begin
             m_jump = m_press;
             if (frame_tick) begin
               if (m_score < 65535) m_score++;
               m_ramp++;
               if (m_ramp == SS) begin
                 m_ramp = 0;
                 m_speed = (m_speed - SST < SMIN) ? SMIN : m_speed - SST;
               end
             end
           end
        default: if (m_press && m_lock >= HOLD) m_new_round();
                 else if (frame_tick && m_lock < HOLD) m_lock++;
      endcase
      // press derives from the debounced level of the twice-delayed button
      m_press = 0;
      if (m_s2 != m_lvl) begin
        m_run++;
        if (m_run == DEB) begin m_lvl = m_s2; m_run = 0; m_press = m_lvl; end
      end else m_run = 0;
      m_s2 = m_s1;
      m_s1 = btn_jump;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("m_state", int'(state), m_st);
    chk("m_halt", int'(halt), int'(m_st != 2));
    chk("m_game_rst", int'(game_rst), int'(m_st == 1));
    chk("m_jump", int'(jump), int'(m_jump));
    chk("m_speed", int'(speed), m_speed);
    chk("m_score", int'(score), m_score);
    chk("m_hi", int'(hi_score), m_hi);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cmp_all();
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(1);
  endtask

  task automatic wait_state(input int s, input int maxc, output bit ok);
    ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      cyc(1);
      if (int'(state) == s) ok = 1;
    end
  endtask

  int spd_tab[12] = '{100, 100, 70, 70, 70, 40, 40, 40, 20, 20, 20, 20};
  int njump, jat, hold;
  bit ok;

  initial begin
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_halt", int'(halt), 1);
    chk("rst_speed", int'(speed), 100);
    chk("rst_hi", int'(hi_score), 0);
    cmp_all();
    @(negedge clk) sys_rst_n = 1'b1;

    // short glitch is rejected, a long press starts a round
    btn_jump = 1'b1; cyc(3); btn_jump = 1'b0; cyc(10);
    chk("glitch_state", int'(state), 0);
    chk("glitch_halt", int'(halt), 1);
    btn_jump = 1'b1;
    wait_state(1, 15, ok);
    chk("start_seen", int'(ok), 1);
    chk("start_grst", int'(game_rst), 1);
    cyc(1);
    chk("run_state", int'(state), 2);
    chk("run_halt", int'(halt), 0);
    chk("run_speed", int'(speed), 100);
    chk("run_score", int'(score), 0);
    btn_jump = 1'b0; cyc(10);

    // held button gives one jump, one cycle after the debounced press
    njump = 0; jat = 0; btn_jump = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      cyc(1);
      if (jump) begin njump++; if (jat == 0) jat = k; end
    end
    chk("jump_count", njump, 1);
    chk("jump_cycle", jat, 7);
    btn_jump = 1'b0; cyc(10);

    // collision with tick and press in the same cycle
    repeat (5) tick();
    chk("pre_die_score", int'(score), 5);
    btn_jump = 1'b1; cyc(6);
    collision = 1'b1; frame_tick = 1'b1; cyc(1);
    collision = 1'b0; frame_tick = 1'b0;
    chk("die_state", int'(state), 3);
    chk("die_score", int'(score), 5);
    chk("die_hi", int'(hi_score), 5);
    cyc(1);
    chk("die_nojump", int'(jump), 0);
    btn_jump = 1'b0; cyc(10);

    // lockout: press after one tick ignored, after two ticks accepted
    tick();
    btn_jump = 1'b1; cyc(12);
    chk("lock_state", int'(state), 3);
    btn_jump = 1'b0; cyc(10);
    tick();
    btn_jump = 1'b1;
    wait_state(1, 15, ok);
    chk("restart_seen", int'(ok), 1);
    chk("restart_grst", int'(game_rst), 1);
    chk("restart_score", int'(score), 0);
    chk("restart_speed", int'(speed), 100);
    btn_jump = 1'b0; cyc(10);
    repeat (2) tick();
    collision = 1'b1; cyc(1); collision = 1'b0;
    chk("die2_score", int'(score), 2);
    chk("die2_hi", int'(hi_score), 5);

    // speed ramp and clamp
    repeat (2) tick();
    btn_jump = 1'b1;
    wait_state(2, 20, ok);
    chk("round3_run", int'(ok), 1);
    btn_jump = 1'b0; cyc(10);
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("ramp_score", int'(score), i);
      chk("ramp_speed", int'(speed), spd_tab[i-1]);
    end

    // asynchronous reset mid-round
    @(posedge clk); #3 sys_rst_n = 1'b0; #1;
    chk("arst_state", int'(state), 0);
    chk("arst_score", int'(score), 0);
    chk("arst_hi", int'(hi_score), 0);
    chk("arst_halt", int'(halt), 1);
    chk("arst_speed", int'(speed), 100);
    cmp_all();
    @(negedge clk) sys_rst_n = 1'b1;

    // random traffic against the model
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin btn_jump = ~btn_jump; hold = $urandom_range(1, 12); end
      hold--;
      frame_tick = ($urandom_range(0, 3) == 0);
      collision  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 999) == 0) begin
        sys_rst_n = 1'b0; #1;
        cmp_all();
        @(negedge clk) sys_rst_n = 1'b1;
      end
      cyc(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
